// File: rtl/gate_response_checker_if.sv
// Stimulus and result bundle between a gate-under-test harness
// and the response checker.
interface gate_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [2:0]       op;
    logic             sample_valid;
    logic             a;
    logic             b;
    logic             x;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       cov;
    logic             first_fail_valid;
    logic [2:0]       first_fail_vec;

    modport master (
        output start, stop, op, sample_valid, a, b, x,
        input  busy, done, pass, smp_cnt, err_cnt, cov,
        input  first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, stop, op, sample_valid, a, b, x,
        output busy, done, pass, smp_cnt, err_cnt, cov,
        output first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/gate_response_checker.sv
// Checks sampled {a,b,x} triples of a 1-bit gate against its truth
// table, tracking counts, input coverage, first failure and a verdict.
module gate_response_checker #(
    parameter int CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    gate_response_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [2:0]       op_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [CNT_W-1:0] smp_q;
    logic [CNT_W-1:0] err_q;
    logic [3:0]       cov_q;
    logic             ffv_q;
    logic [2:0]       ffvec_q;

    logic             exp_x;
    logic             take;
    logic             mismatch;
    logic [1:0]       idx;
    logic [3:0]       cov_nxt;
    logic [CNT_W-1:0] smp_nxt;
    logic [CNT_W-1:0] err_nxt;
    logic             finish;

    always_comb begin
        exp_x = 1'b0;
        case (op_q)
            3'b000:  exp_x = bus.a & bus.b;
            3'b001:  exp_x = bus.a | bus.b;
            3'b010:  exp_x = ~bus.a;
            3'b011:  exp_x = ~(bus.a & bus.b);
            3'b100:  exp_x = ~(bus.a | bus.b);
            3'b101:  exp_x = bus.a ^ bus.b;
            3'b110:  exp_x = ~(bus.a ^ bus.b);
            default: exp_x = bus.a;
        endcase
    end

    // A sample coinciding with start belongs to no session.
    always_comb begin
        idx      = {bus.a, bus.b};
        take     = (state == RUN) && bus.sample_valid && !bus.start;
        mismatch = take && (bus.x != exp_x);
        cov_nxt  = cov_q;
        smp_nxt  = smp_q;
        err_nxt  = err_q;
        if (take) begin
            cov_nxt = cov_q | (4'b0001 << idx);
            if (smp_q != CNT_MAX) smp_nxt = smp_q + 1'b1;
        end
        if (mismatch && (err_q != CNT_MAX)) begin
            err_nxt = err_q + 1'b1;
        end
        finish = bus.stop || (cov_nxt == 4'hF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            smp_q   <= '0;
            err_q   <= '0;
            cov_q   <= 4'h0;
            ffv_q   <= 1'b0;
            ffvec_q <= 3'b000;
        end else if (bus.start) begin
            state   <= RUN;
            op_q    <= bus.op;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            smp_q   <= '0;
            err_q   <= '0;
            cov_q   <= 4'h0;
            ffv_q   <= 1'b0;
            ffvec_q <= 3'b000;
        end else begin
            case (state)
                RUN: begin
                    smp_q <= smp_nxt;
                    err_q <= err_nxt;
                    cov_q <= cov_nxt;
                    if (mismatch && !ffv_q) begin
                        ffv_q   <= 1'b1;
                        ffvec_q <= {bus.a, bus.b, bus.x};
                    end
                    if (finish) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_nxt == '0) && (cov_nxt == 4'hF);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.smp_cnt          = smp_q;
    assign bus.err_cnt          = err_q;
    assign bus.cov              = cov_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
endmodule

// File: tb/tb_gate_response_checker.sv
// Randomized and directed bench for gate_response_checker against a
// truth-table session model.
module tb_gate_response_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gate_response_checker_if #(.CNT_W(8)) bus ();
    gate_response_checker_if #(.CNT_W(2)) sbus ();

    assign sbus.start        = bus.start;
    assign sbus.stop         = bus.stop;
    assign sbus.op           = bus.op;
    assign sbus.sample_valid = bus.sample_valid;
    assign sbus.a            = bus.a;
    assign sbus.b            = bus.b;
    assign sbus.x            = bus.x;

    gate_response_checker #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    gate_response_checker #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    // Truth tables, bit {a,b} holds the expected output.
    logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                           4'b0001, 4'b0110, 4'b1001, 4'b1100};

    int         m_state;
    int         m_smp;
    int         m_err;
    logic [3:0] m_cov;
    logic       m_ffv;
    logic [2:0] m_ffvec;
    logic       m_pass;
    logic [2:0] m_op;

    task automatic model_reset();
        m_state = 0; m_smp = 0; m_err = 0; m_cov = 0;
        m_ffv = 0; m_ffvec = 0; m_pass = 0; m_op = 0;
    endtask

    task automatic model_step(input logic st, sp, input logic [2:0] o,
                              input logic sv, aa, bb, xx);
        int k;
        k = {aa, bb};
        if (st) begin
            m_state = 1; m_smp = 0; m_err = 0; m_cov = 0;
            m_ffv = 0; m_ffvec = 0; m_pass = 0; m_op = o;
        end else if (m_state == 1) begin
            if (sv) begin
                if (m_smp < 255) m_smp++;
                m_cov[k] = 1'b1;
                if (xx != tt[m_op][k]) begin
                    if (m_err < 255) m_err++;
                    if (!m_ffv) begin m_ffv = 1; m_ffvec = {aa, bb, xx}; end
                end
            end
            if (sp || m_cov == 4'hF) begin
                m_state = 2;
                m_pass = (m_err == 0) && (m_cov == 4'hF);
            end
        end
    endtask

    task automatic apply(input logic st, sp, input logic [2:0] o,
                         input logic sv, aa, bb, xx);
        @(negedge clk);
        bus.start = st; bus.stop = sp; bus.op = o;
        bus.sample_valid = sv; bus.a = aa; bus.b = bb; bus.x = xx;
        model_step(st, sp, o, sv, aa, bb, xx);
        @(posedge clk);
        #1;
        bus.start = 0; bus.stop = 0; bus.sample_valid = 0;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.stop = 0; bus.op = 0;
        bus.sample_valid = 0; bus.a = 0; bus.b = 0; bus.x = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.pass}); end
        n_tests++; if ({bus.smp_cnt, bus.err_cnt} !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", {bus.smp_cnt, bus.err_cnt}); end
        n_tests++; if ({bus.cov, bus.first_fail_valid, bus.first_fail_vec} !== 8'h0) begin n_fail++; $display("FAIL reset_cov_ff: got %h want 00", {bus.cov, bus.first_fail_valid, bus.first_fail_vec}); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_nor();
        apply(1, 0, 3'b100, 0, 0, 0, 0);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL nor_busy: got %b want 1", bus.busy); end
        apply(0, 0, 3'b000, 1, 0, 0, 1);
        apply(0, 0, 3'b000, 1, 0, 1, 0);
        apply(0, 0, 3'b000, 1, 1, 0, 0);
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL nor_early_done: got %b want 0", bus.done); end
        apply(0, 0, 3'b000, 1, 1, 1, 0);
        n_tests++; if ({bus.done, bus.busy, bus.pass} !== 3'b101) begin n_fail++; $display("FAIL nor_flags: got %b want 101", {bus.done, bus.busy, bus.pass}); end
        n_tests++; if (bus.smp_cnt !== 8'd4 || bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL nor_cnt: got %0d/%0d want 4/0", bus.smp_cnt, bus.err_cnt); end
        n_tests++; if (bus.cov !== 4'hF || bus.first_fail_valid !== 1'b0) begin n_fail++; $display("FAIL nor_cov: got %b/%b want 1111/0", bus.cov, bus.first_fail_valid); end
    endtask

    task automatic test_faulty_and();
        apply(1, 0, 3'b000, 0, 0, 0, 0);
        apply(0, 0, 3'b111, 1, 0, 0, 0);
        apply(0, 0, 3'b111, 1, 0, 1, 1);
        apply(0, 0, 3'b111, 1, 1, 0, 0);
        apply(0, 0, 3'b111, 1, 1, 1, 0);
        n_tests++; if (bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL and_err: got %0d want 2", bus.err_cnt); end
        n_tests++; if (bus.first_fail_vec !== 3'b011 || bus.first_fail_valid !== 1'b1) begin n_fail++; $display("FAIL and_ff: got %b/%b want 011/1", bus.first_fail_vec, bus.first_fail_valid); end
        n_tests++; if ({bus.done, bus.pass} !== 2'b10) begin n_fail++; $display("FAIL and_verdict: got %b want 10", {bus.done, bus.pass}); end
    endtask

    task automatic test_early_stop();
        apply(1, 0, 3'b101, 0, 0, 0, 0);
        apply(0, 0, 3'b000, 1, 0, 0, 0);
        apply(0, 0, 3'b000, 1, 0, 1, 1);
        apply(0, 1, 3'b000, 0, 0, 0, 0);
        n_tests++; if ({bus.done, bus.pass, bus.cov} !== 6'b10_0011) begin n_fail++; $display("FAIL stop_state: got %b want 100011", {bus.done, bus.pass, bus.cov}); end
        n_tests++; if (bus.smp_cnt !== 8'd2 || bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL stop_cnt: got %0d/%0d want 2/0", bus.smp_cnt, bus.err_cnt); end
        apply(0, 0, 3'b000, 1, 1, 1, 1);
        n_tests++; if ({bus.done, bus.pass, bus.cov, bus.smp_cnt, bus.err_cnt, bus.first_fail_valid} !== {2'b10, 4'b0011, 8'd2, 8'd0, 1'b0}) begin n_fail++; $display("FAIL stop_hold: got %h", {bus.done, bus.pass, bus.cov, bus.smp_cnt, bus.err_cnt, bus.first_fail_valid}); end
    endtask

    task automatic test_collision();
        apply(1, 0, 3'b100, 0, 0, 0, 0);
        repeat (3) apply(0, 0, 3'b000, 1, 0, 0, 1);
        n_tests++; if (bus.smp_cnt !== 8'd3 || bus.cov !== 4'b0001) begin n_fail++; $display("FAIL dup: got %0d/%b want 3/0001", bus.smp_cnt, bus.cov); end
        apply(1, 1, 3'b100, 1, 1, 1, 1);
        n_tests++; if (bus.smp_cnt !== 8'd0 || bus.cov !== 4'b0000 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL collide: got %0d/%b/%b want 0/0000/1", bus.smp_cnt, bus.cov, bus.busy); end
        apply(0, 0, 3'b000, 1, 0, 1, 0);
        n_tests++; if (bus.smp_cnt !== 8'd1 || bus.cov !== 4'b0010 || bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL after_collide: got %0d/%b/%0d want 1/0010/0", bus.smp_cnt, bus.cov, bus.err_cnt); end
    endtask

    task automatic test_async_reset();
        apply(1, 0, 3'b001, 0, 0, 0, 0);
        apply(0, 0, 3'b000, 1, 0, 0, 1);
        apply(0, 0, 3'b000, 1, 0, 1, 1);
        #2 rst = 1;
        #1;
        model_reset();
        n_tests++; if ({bus.busy, bus.done, bus.pass, bus.first_fail_valid} !== 4'b0) begin n_fail++; $display("FAIL arst_flags: got %b want 0000", {bus.busy, bus.done, bus.pass, bus.first_fail_valid}); end
        n_tests++; if ({bus.smp_cnt, bus.err_cnt, bus.cov, bus.first_fail_vec} !== 23'h0) begin n_fail++; $display("FAIL arst_vals: got %h want 0", {bus.smp_cnt, bus.err_cnt, bus.cov, bus.first_fail_vec}); end
        @(negedge clk);
        rst = 0;
        apply(0, 0, 3'b000, 1, 1, 1, 0);
        n_tests++; if ({bus.busy, bus.smp_cnt, bus.cov} !== 13'h0) begin n_fail++; $display("FAIL idle_ignore: got %h want 0", {bus.busy, bus.smp_cnt, bus.cov}); end
    endtask

    task automatic test_saturation();
        apply(1, 0, 3'b011, 0, 0, 0, 0);
        repeat (5) apply(0, 0, 3'b000, 1, 0, 0, 0);
        n_tests++; if (sbus.err_cnt !== 2'd3 || sbus.smp_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_cnt: got %0d/%0d want 3/3", sbus.err_cnt, sbus.smp_cnt); end
        n_tests++; if (bus.err_cnt !== 8'd5) begin n_fail++; $display("FAIL wide_err: got %0d want 5", bus.err_cnt); end
        apply(0, 1, 3'b000, 0, 0, 0, 0);
        n_tests++; if ({sbus.done, sbus.pass, sbus.err_cnt} !== 4'b1011) begin n_fail++; $display("FAIL sat_stop: got %b want 1011", {sbus.done, sbus.pass, sbus.err_cnt}); end
    endtask

    task automatic test_random();
        logic st, sp, sv, aa, bb, xx;
        logic [2:0] o;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom % 18) == 0;
            sp = ($urandom % 25) == 0;
            sv = ($urandom % 4) != 0;
            o  = 3'($urandom);
            aa = 1'($urandom);
            bb = 1'($urandom);
            xx = tt[m_op][{aa, bb}] ^ (($urandom % 6) == 0);
            apply(st, sp, o, sv, aa, bb, xx);
            n_tests++; if (bus.busy !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, bus.busy, m_state == 1); end
            n_tests++; if (bus.done !== (m_state == 2)) begin n_fail++; $display("FAIL rnd_done[%0d]: got %b want %b", i, bus.done, m_state == 2); end
            n_tests++; if (bus.pass !== m_pass) begin n_fail++; $display("FAIL rnd_pass[%0d]: got %b want %b", i, bus.pass, m_pass); end
            n_tests++; if (bus.smp_cnt !== 8'(m_smp)) begin n_fail++; $display("FAIL rnd_smp[%0d]: got %0d want %0d", i, bus.smp_cnt, m_smp); end
            n_tests++; if (bus.err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %0d want %0d", i, bus.err_cnt, m_err); end
            n_tests++; if (bus.cov !== m_cov) begin n_fail++; $display("FAIL rnd_cov[%0d]: got %b want %b", i, bus.cov, m_cov); end
            n_tests++; if (bus.first_fail_valid !== m_ffv) begin n_fail++; $display("FAIL rnd_ffv[%0d]: got %b want %b", i, bus.first_fail_valid, m_ffv); end
            n_tests++; if (bus.first_fail_vec !== m_ffvec) begin n_fail++; $display("FAIL rnd_ffvec[%0d]: got %b want %b", i, bus.first_fail_vec, m_ffvec); end
        end
    endtask

    initial begin
        test_reset();
        test_nor();
        test_faulty_and();
        test_early_stop();
        test_collision();
        test_async_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
